// File: rtl/sram_request_queue_if.sv
// Host request port and state-machine replay channels
// for the SRAM request queue.
interface sram_request_queue_if #(
  parameter int CMD_WIDTH  = 4,
  parameter int DATA_WIDTH = 16
);
  logic [CMD_WIDTH-1:0]  req_cmd;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_has_data;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] receive;
  logic                  dfcq_valid;
  logic                  dfcq_ready;
  logic [CMD_WIDTH-1:0]  offer;
  logic                  offer_valid;
  logic                  offer_ready;

  modport master (
    output req_cmd, req_data, req_has_data, req_valid,
    output dfcq_ready, offer_ready,
    input  req_ready, receive, dfcq_valid,
    input  offer, offer_valid
  );

  modport slave (
    input  req_cmd, req_data, req_has_data, req_valid,
    input  dfcq_ready, offer_ready,
    output req_ready, receive, dfcq_valid,
    output offer, offer_valid
  );
endinterface

// File: rtl/sram_request_queue.sv
// Request FIFO replaying data then command to the SRAM FSM.
// Optional stats counters: define SRAM_REQ_QUEUE_STATS_EN.
module sram_request_queue #(
  parameter int DEPTH      = 4,
  parameter int CMD_WIDTH  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  sram_request_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] queue_level
`ifdef SRAM_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]            cmd_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [DATA_WIDTH-1:0] data;
    logic                  has_data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CMD  = 2'd2
  } state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  state_t        state;
  state_t        state_nx;
  entry_t        head;
  entry_t        nxt_head;
  entry_t        wr_entry;
  logic          push;
  logic          pop;
  logic          dv;
  logic          ov;

  assign bus.req_ready = ASYNCRESETN
                       && (count < LW'(DEPTH));
  assign push     = bus.req_valid && bus.req_ready;
  assign wr_entry = {bus.req_cmd, bus.req_data,
                     bus.req_has_data};
  assign head     = mem[rd_ptr];
  // With one entry left, the follow-on head is the one
  // being written this same cycle.
  assign nxt_head = (count > LW'(1))
                  ? mem[rd_ptr + AW'(1)]
                  : wr_entry;

  always_comb begin
    state_nx = state;
    dv       = 1'b0;
    ov       = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0)
          state_nx = head.has_data ? DATA : CMD;
      end
      DATA: begin
        dv = 1'b1;
        if (bus.dfcq_ready) state_nx = CMD;
      end
      CMD: begin
        ov = 1'b1;
        if (bus.offer_ready) begin
          pop = 1'b1;
          if (count > LW'(1) || push)
            state_nx = nxt_head.has_data ? DATA : CMD;
          else
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dfcq_valid  = dv;
  assign bus.offer_valid = ov;
  assign bus.receive     = head.data;
  assign bus.offer       = head.cmd;
  assign queue_level     = count;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push) - LW'(pop);
    end
  end

`ifdef SRAM_REQ_QUEUE_STATS_EN
  logic stall;
  assign stall = bus.req_valid && !bus.req_ready;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cmd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pop && cmd_count != 16'hFFFF)
        cmd_count <= cmd_count + 16'd1;
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_request_queue.sv
// Scoreboard bench for sram_request_queue.
// Replayed data/cmd words are checked in FIFO order.
module tb_sram_request_queue;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [2:0]  queue_level;
  int          total = 0;
  int          bad   = 0;
  bit          rand_rdy = 1'b0;

  typedef struct {
    bit          is_data;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  sram_request_queue_if #(.CMD_WIDTH(4), .DATA_WIDTH(16)) bus ();

`ifdef SRAM_REQ_QUEUE_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] stall_count;
  logic [15:0] m_cmd;
  logic [15:0] m_stall;
`endif

  sram_request_queue #(
    .DEPTH(4), .CMD_WIDTH(4), .DATA_WIDTH(16)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (rst_n),
    .bus         (bus),
    .queue_level (queue_level)
`ifdef SRAM_REQ_QUEUE_STATS_EN
    ,
    .cmd_count   (cmd_count),
    .stall_count (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every handshake is judged mid-cycle, before
  // the edge on which it completes.
  always @(negedge CLK) begin
    exp_t e;
    if (rst_n) begin
      chk("one_valid",
          32'(bus.dfcq_valid && bus.offer_valid), 0);
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_has_data)
          sb.push_back('{1'b1, bus.req_data});
        sb.push_back('{1'b0, {12'b0, bus.req_cmd}});
      end
      if (bus.dfcq_valid && bus.dfcq_ready) begin
        if (sb.size() == 0) chk("sb_under_d", 1, 0);
        else begin
          e = sb.pop_front();
          chk("kind_d", 32'(e.is_data), 1);
          chk("receive", 32'(bus.receive), 32'(e.val));
        end
      end
      if (bus.offer_valid && bus.offer_ready) begin
        if (sb.size() == 0) chk("sb_under_c", 1, 0);
        else begin
          e = sb.pop_front();
          chk("kind_c", 32'(e.is_data), 0);
          chk("offer", 32'(bus.offer), 32'(e.val));
        end
      end
    end
  end

`ifdef SRAM_REQ_QUEUE_STATS_EN
  always @(negedge CLK) begin
    if (!rst_n) begin
      m_cmd   <= '0;
      m_stall <= '0;
    end else begin
      if (bus.offer_valid && bus.offer_ready
          && m_cmd != 16'hFFFF)
        m_cmd <= m_cmd + 16'd1;
      if (bus.req_valid && !bus.req_ready
          && m_stall != 16'hFFFF)
        m_stall <= m_stall + 16'd1;
    end
  end
`endif

  task automatic rnd_rdy();
    if (rand_rdy) begin
      bus.dfcq_ready  = 1'($urandom_range(0, 1));
      bus.offer_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the
  // accepting edge.
  task automatic push_req(input logic [3:0] c,
                          input logic [15:0] d,
                          input bit h);
    bit got = 1'b0;
    bus.req_cmd      = c;
    bus.req_data     = d;
    bus.req_has_data = h;
    bus.req_valid    = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      rnd_rdy();
    end
    if (!got) chk("push_timeout", 1, 0);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    rnd_rdy();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (queue_level == 0 && !bus.dfcq_valid
          && !bus.offer_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_sig(input string tag,
                          input bit want_offer);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (want_offer ? bus.offer_valid
                     : bus.dfcq_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_cmd      = '0;
    bus.req_data     = '0;
    bus.req_has_data = 1'b0;
    bus.req_valid    = 1'b0;
    bus.dfcq_ready   = 1'b1;
    bus.offer_ready  = 1'b1;

    // reset state
    #3;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_level", 32'(queue_level), 0);
    chk("rst_dv", 32'(bus.dfcq_valid), 0);
    chk("rst_ov", 32'(bus.offer_valid), 0);
    chk("rst_offer", 32'(bus.offer), 0);
    chk("rst_recv", 32'(bus.receive), 0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 32'(bus.req_ready), 1);
    @(posedge CLK); #1;

    // single write request, latency and ordering
    push_req(4'd1, 16'h00AB, 1'b1);
    @(negedge CLK);
    chk("wr_lvl1", 32'(queue_level), 1);
    chk("wr_dv_early", 32'(bus.dfcq_valid), 0);
    @(negedge CLK);
    chk("wr_dv", 32'(bus.dfcq_valid), 1);
    chk("wr_recv", 32'(bus.receive), 32'h00AB);
    @(negedge CLK);
    chk("wr_ov", 32'(bus.offer_valid), 1);
    chk("wr_offer", 32'(bus.offer), 1);
    @(negedge CLK);
    chk("wr_lvl0", 32'(queue_level), 0);
    chk("wr_ov_off", 32'(bus.offer_valid), 0);
    @(posedge CLK); #1;

    // data-less request
    push_req(4'd0, 16'hFFFF, 1'b0);
    @(negedge CLK);
    chk("nd_dv0", 32'(bus.dfcq_valid), 0);
    @(negedge CLK);
    chk("nd_ov", 32'(bus.offer_valid), 1);
    chk("nd_offer", 32'(bus.offer), 0);
    chk("nd_dv1", 32'(bus.dfcq_valid), 0);
    wait_idle("nd_idle");

    // fill and backpressure
    bus.dfcq_ready  = 1'b0;
    bus.offer_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(4'(i + 2), 16'h0100 + 16'(i), i[0]);
    bus.req_cmd      = 4'hE;
    bus.req_data     = 16'hBEEF;
    bus.req_has_data = 1'b1;
    bus.req_valid    = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("full_ready", 32'(bus.req_ready), 0);
      chk("full_level", 32'(queue_level), 4);
    end
    @(posedge CLK); #1;
    bus.dfcq_ready  = 1'b1;
    bus.offer_ready = 1'b1;
    push_req(4'hE, 16'hBEEF, 1'b1);
    wait_idle("fill_idle");
    chk("fill_sb", 32'(sb.size()), 0);

    // stall hold on data channel
    bus.dfcq_ready = 1'b0;
    push_req(4'd7, 16'h5A5A, 1'b1);
    wait_sig("stall_dv", 1'b0);
    repeat (10) begin
      @(negedge CLK);
      chk("stall_dv", 32'(bus.dfcq_valid), 1);
      chk("stall_recv", 32'(bus.receive), 32'h5A5A);
      chk("stall_ov", 32'(bus.offer_valid), 0);
    end
    @(posedge CLK); #1;
    bus.dfcq_ready = 1'b1;
    wait_idle("stall_idle");

    // simultaneous push and pop at level 2
    bus.offer_ready = 1'b0;
    push_req(4'd3, 16'h0000, 1'b0);
    push_req(4'd4, 16'h0000, 1'b0);
    wait_sig("sim_ov", 1'b1);
    @(posedge CLK); #1;
    bus.offer_ready  = 1'b1;
    bus.req_cmd      = 4'd5;
    bus.req_data     = 16'h1234;
    bus.req_has_data = 1'b1;
    bus.req_valid    = 1'b1;
    @(negedge CLK);
    chk("sim_lvl_pre", 32'(queue_level), 2);
    chk("sim_ready", 32'(bus.req_ready), 1);
    @(posedge CLK); #1;
    bus.req_valid   = 1'b0;
    bus.offer_ready = 1'b0;
    @(negedge CLK);
    chk("sim_lvl_post", 32'(queue_level), 2);
    @(posedge CLK); #1;
    bus.offer_ready = 1'b1;
    wait_idle("sim_idle");

    // pointer wrap with random readies
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_req(4'($urandom_range(0, 15)),
               16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
        rnd_rdy();
      end
    end
    rand_rdy        = 1'b0;
    bus.dfcq_ready  = 1'b1;
    bus.offer_ready = 1'b1;
    wait_idle("wrap_idle");
    chk("wrap_sb", 32'(sb.size()), 0);

    // reset mid-replay during CMD
    bus.offer_ready = 1'b0;
    push_req(4'd9, 16'h0, 1'b0);
    push_req(4'd10, 16'h0, 1'b0);
    push_req(4'd11, 16'h0, 1'b0);
    wait_sig("mid_ov", 1'b1);
    @(posedge CLK); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_ov_drop", 32'(bus.offer_valid), 0);
    chk("mid_dv_drop", 32'(bus.dfcq_valid), 0);
    chk("mid_ready", 32'(bus.req_ready), 0);
    chk("mid_level", 32'(queue_level), 0);
    chk("mid_offer", 32'(bus.offer), 0);
    @(negedge CLK);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    chk("post_level", 32'(queue_level), 0);
    chk("post_ready", 32'(bus.req_ready), 1);
`ifdef SRAM_REQ_QUEUE_STATS_EN
    chk("post_cmdcnt", 32'(cmd_count), 0);
    chk("post_stallcnt", 32'(stall_count), 0);
`endif
    @(posedge CLK); #1;
    bus.offer_ready = 1'b1;
    push_req(4'd6, 16'hC0DE, 1'b1);
    wait_idle("post_idle");

`ifdef SRAM_REQ_QUEUE_STATS_EN
    // prolonged stall drives the counter to saturation
    bus.dfcq_ready  = 1'b0;
    bus.offer_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(4'(i), 16'(i), 1'b0);
    bus.req_cmd   = 4'd8;
    bus.req_valid = 1'b1;
    repeat (65540) @(posedge CLK);
    @(negedge CLK);
    chk("stall_sat", 32'(stall_count), 32'hFFFF);
    chk("stall_model", 32'(stall_count), 32'(m_stall));
    @(posedge CLK); #1;
    bus.offer_ready = 1'b1;
    bus.dfcq_ready  = 1'b1;
    push_req(4'd8, 16'h0, 1'b0);
    wait_idle("sat_idle");
    chk("cmd_model", 32'(cmd_count), 32'(m_cmd));
`endif

    chk("final_sb", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_request_queue.md
# sram_request_queue

Upstream feeder for the SRAM subsystem control state machine. Accepts host requests (4-bit command plus optional 16-bit data word) on a valid/ready port and buffers them in a DEPTH-entry FIFO. For each request it replays the data word on the `receive`/`dfcq_valid` channel and then the command on the `offer`/`offer_valid` channel, which is the order the state machine consumes them. It decouples host burstiness from the state machine's one-request-at-a-time sequencing.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CMD_WIDTH`, 4: command width.
- `DATA_WIDTH`, 16: data word width.
- `CLK` in 1: single clock, rising edge.
- `ASYNCRESETN` in 1: reset, asynchronous and active-low.
- `req_cmd` in CMD_WIDTH: host command.
- `req_data` in DATA_WIDTH: host data word.
- `req_has_data` in 1: request carries a data word.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: queue can accept.
- `receive` out DATA_WIDTH: data word to state machine.
- `dfcq_valid` out 1: `receive` valid.
- `dfcq_ready` in 1: state machine takes data.
- `offer` out CMD_WIDTH: command to state machine.
- `offer_valid` out 1: `offer` valid.
- `offer_ready` in 1: state machine takes command.
- `queue_level` out clog2(DEPTH)+1: registered occupancy.

## Operation
- Push: on `req_valid && req_ready`, write {cmd, data, has_data} at the write pointer.
- `req_ready = (count < DEPTH)`, computed from the registered count. No same-cycle pop pass-through, so a full queue stays not-ready even during a pop.
- Replay FSM, states IDLE(0), DATA(1), CMD(2):
  - IDLE: if count > 0, go to DATA when the head has data, else go to CMD.
  - DATA: `dfcq_valid = 1`, `receive` = head data. On `dfcq_ready`, go to CMD.
  - CMD: `offer_valid = 1`, `offer` = head cmd. On `offer_ready`, pop the head. If count after the pop is > 0, go directly to DATA or CMD for the new head. Otherwise go to IDLE.
- Only one of `dfcq_valid` and `offer_valid` is high at a time. The valid and the presented value hold stable until the handshake.
- `offer` and `receive` show the head entry at all times; their values are don't-care-free because storage resets to 0.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push into an empty queue while the FSM is in IDLE: the entry is visible on the next cycle.

## Timing
- Reset (`ASYNCRESETN` low) takes effect immediately:
  - count = 0, pointers = 0, storage = 0, FSM = IDLE.
  - `req_ready`, `dfcq_valid` and `offer_valid` are held at 0 while reset is asserted.
  - `offer` = 0, `receive` = 0, `queue_level` = 0.
- After reset release, `req_ready` = 1 in the first cycle.
- Reset mid-operation discards all entries and any partially replayed request. No handshake completes in the reset cycle.
- Latency: a push accepted at edge E0 produces `dfcq_valid` (or `offer_valid` for a data-less request) in the cycle after edge E1.
- Throughput: one handshake per cycle when the downstream ready is held high.
  - A data-carrying request costs 2 cycles; a data-less request costs 1.
  - There is no IDLE bubble between back-to-back entries.
- `queue_level` updates on the edge of each push or pop.

## Configuration
- `SRAM_REQ_QUEUE_STATS_EN` defined: adds two outputs, each saturating at 0xFFFF and reset to 0.
  - `cmd_count[15:0]`: counts `offer` handshakes.
  - `stall_count[15:0]`: counts cycles with `req_valid && !req_ready`.
- `SRAM_REQ_QUEUE_STATS_EN` undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Single write request, readies held high: push cmd=1, data=0x00AB, has_data=1 → `dfcq_valid` with `receive`=0x00AB two cycles later, then `offer_valid` with `offer`=1 the next cycle, then `queue_level` returns to 0.
- Data-less request: push cmd=0, has_data=0 → `offer_valid`=1, `offer`=0 two cycles later; `dfcq_valid` never asserts.
- Fill and backpressure: readies low, push 5 requests → `req_ready`=0 after 4 pushes with `queue_level`=4 and the 5th request held. Raise the readies → all 4 replay in FIFO order, then the 5th is accepted.
- Stall hold: `dfcq_ready`=0 for 10 cycles while DATA is presented → `receive` and `dfcq_valid` stay stable; `offer_valid` stays 0.
- Simultaneous push and pop at `queue_level`=2 → level stays 2; pointer wrap is exercised over 3×DEPTH requests with no loss or reorder.
- Reset mid-replay during CMD with 3 entries queued → all valids drop in the same cycle; after release `queue_level`=0. With stats enabled, `cmd_count` and `stall_count` read 0 and saturate at 0xFFFF under prolonged stall.
